trig_pipe: RTL and testbench

Pipelined, parametrised full-circle sine/cosine generator for the beam-steering and transmit-waveform paths. It stores a quarter-wave table and folds any phase in [0, 2π) onto it, producing signed sin and cos together. It accepts one phase per cycle, either from an external strobe or from an internal phase-accumulator sweep engine. It replaces the unsigned half-wave sine table wherever signed results, cosine, or generated tone bursts are required.

---
 rtl/trig_pipe_if.sv | 29 ++
 rtl/trig_pipe.sv | 161 ++++++++++++++++
 tb/tb_trig_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/trig_pipe_if.sv
// Request/response bundle for the trig_pipe sine/cosine generator.
// The requester uses the master modport and the generator uses the slave modport.
interface trig_pipe_if #(
    parameter int ANGLE_WIDTH = 9,
    parameter int OUT_WIDTH   = 16,
    parameter int LEN_WIDTH   = 16
);
    logic                          valid_in;
    logic [ANGLE_WIDTH-1:0]        angle_in;
    logic                          sweep_start_in;
    logic [ANGLE_WIDTH-1:0]        step_in;
    logic [LEN_WIDTH-1:0]          len_in;
    logic signed [OUT_WIDTH-1:0]   sin_out;
    logic signed [OUT_WIDTH-1:0]   cos_out;
    logic [ANGLE_WIDTH-1:0]        angle_out;
    logic                          valid_out;
    logic                          last_out;
    logic                          busy_out;

    modport master (
        output valid_in, angle_in, sweep_start_in, step_in, len_in,
        input  sin_out, cos_out, angle_out, valid_out, last_out, busy_out
    );

    modport slave (
        input  valid_in, angle_in, sweep_start_in, step_in, len_in,
        output sin_out, cos_out, angle_out, valid_out, last_out, busy_out
    );
endinterface

// File: rtl/trig_pipe.sv
// Three-stage full-circle sin/cos generator built on a quarter-wave table.
// Phases come from single requests or from an internal phase-accumulator sweep.
module trig_pipe #(
    parameter int ANGLE_WIDTH = 9,
    parameter int OUT_WIDTH   = 16,
    parameter int LEN_WIDTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    trig_pipe_if.slave  bus
);
    localparam int  Q     = 2 ** (ANGLE_WIDTH - 2);
    localparam int  IW    = ANGLE_WIDTH - 1;
    localparam int  RW    = ANGLE_WIDTH - 2;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP_R = (2.0 ** (OUT_WIDTH - 1)) - 1.0;

    typedef enum logic {IDLE, SWEEP} state_t;

    function automatic logic [OUT_WIDTH-1:0] table_entry(input int k);
        real x;
        x = AMP_R * $sin(PI / 2.0 * real'(k) / real'(Q));
        return OUT_WIDTH'($rtoi(x + 0.5));
    endfunction

    // Odd quadrants read the table mirrored about Q.
    function automatic logic [IW-1:0] fold_index(input logic [ANGLE_WIDTH-1:0] p);
        logic [IW-1:0] r;
        r = IW'(p[RW-1:0]);
        return p[ANGLE_WIDTH-2] ? (IW'(Q) - r) : r;
    endfunction

    logic [OUT_WIDTH-1:0] quarter [Q+1];
    for (genvar k = 0; k <= Q; k++) begin : g_table
        assign quarter[k] = table_entry(k);
    end

    state_t                 state, state_nxt;
    logic [ANGLE_WIDTH-1:0] phase_acc, step_q;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   start_ok;
    logic                   issue_valid, issue_last;
    logic [ANGLE_WIDTH-1:0] issue_angle;

    assign start_ok = bus.sweep_start_in && (bus.len_in != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && bus.len_in != LEN_WIDTH'(1)) state_nxt = SWEEP;
            SWEEP:   if (remaining == LEN_WIDTH'(1))              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        issue_angle = bus.angle_in;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    issue_valid = 1'b1;
                    issue_last  = (bus.len_in == LEN_WIDTH'(1));
                end else if (bus.valid_in) begin
                    issue_valid = 1'b1;
                end
            end
            SWEEP: begin
                issue_valid = 1'b1;
                issue_angle = phase_acc;
                issue_last  = (remaining == LEN_WIDTH'(1));
            end
            default: ;
        endcase
    end

    assign bus.busy_out = (state == SWEEP);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_acc <= '0;
            remaining <= '0;
            step_q    <= '0;
        end else if (state == IDLE && start_ok) begin
            phase_acc <= bus.angle_in + bus.step_in;
            remaining <= bus.len_in - LEN_WIDTH'(1);
            step_q    <= bus.step_in;
        end else if (state == SWEEP) begin
            phase_acc <= phase_acc + step_q;
            remaining <= remaining - LEN_WIDTH'(1);
        end
    end

    logic                   s1_valid, s1_last, s2_valid, s2_last;
    logic [ANGLE_WIDTH-1:0] s1_angle, s2_angle, cos_angle;
    logic [OUT_WIDTH-1:0]   s2_sin_mag, s2_cos_mag;
    logic                   s2_sin_neg, s2_cos_neg;

    assign cos_angle = s1_angle + ANGLE_WIDTH'(Q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s1_valid <= issue_valid;
            s1_last  <= issue_valid && issue_last;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed when their valid flag is set.
    always_ff @(posedge clk_in) begin
        s1_angle   <= issue_angle;
        s2_angle   <= s1_angle;
        s2_sin_mag <= quarter[fold_index(s1_angle)];
        s2_cos_mag <= quarter[fold_index(cos_angle)];
        s2_sin_neg <= s1_angle[ANGLE_WIDTH-1];
        s2_cos_neg <= cos_angle[ANGLE_WIDTH-1];
    end

    logic [OUT_WIDTH-1:0]   sin_q, cos_q;
    logic [ANGLE_WIDTH-1:0] angle_q;
    logic                   valid_q, last_q;

    // Data outputs hold their last value between valid samples.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sin_q   <= '0;
            cos_q   <= '0;
            angle_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= s2_valid;
            last_q  <= s2_last;
            if (s2_valid) begin
                sin_q   <= s2_sin_neg ? -s2_sin_mag : s2_sin_mag;
                cos_q   <= s2_cos_neg ? -s2_cos_mag : s2_cos_mag;
                angle_q <= s2_angle;
            end
        end
    end

    assign bus.sin_out   = sin_q;
    assign bus.cos_out   = cos_q;
    assign bus.angle_out = angle_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
endmodule

// File: tb/tb_trig_pipe.sv
// Directed bench for trig_pipe: single requests, sweeps, reset abort and edge cases.
// Expected values come from hand constants and a real-valued sin/cos model.
module tb_trig_pipe;
    localparam int  N   = 512;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = 32767.0;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    trig_pipe_if #(.ANGLE_WIDTH(9), .OUT_WIDTH(16), .LEN_WIDTH(16)) bus ();

    trig_pipe #(.ANGLE_WIDTH(9), .OUT_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    function automatic int round_sym(input real x);
        return (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
    endfunction

    function automatic int ref_sin(input int p);
        return round_sym(AMP * $sin(2.0 * PI * real'(p) / real'(N)));
    endfunction

    function automatic int ref_cos(input int p);
        return round_sym(AMP * $cos(2.0 * PI * real'(p) / real'(N)));
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_sample(input string tag, input int p, input int last);
        longint pw;
        check({tag, " valid"}, 32'(bus.valid_out), 1);
        check({tag, " angle"}, 32'(bus.angle_out), p);
        check({tag, " sin"}, $signed(bus.sin_out), ref_sin(p));
        check({tag, " cos"}, $signed(bus.cos_out), ref_cos(p));
        check({tag, " last"}, 32'(bus.last_out), last);
        pw = longint'($signed(bus.sin_out)) ** 2 + longint'($signed(bus.cos_out)) ** 2
             - longint'(32767) * 32767;
        check({tag, " power"}, 32'(pw <= 2 * 32767 && pw >= -2 * 32767), 1);
    endtask

    task automatic single(input int p, input int es, input int ec);
        bus.valid_in = 1'b1;
        bus.angle_in = 9'(p);
        tick();
        bus.valid_in = 1'b0;
        check("single early", 32'(bus.valid_out), 0);
        tick();
        tick();
        check("single valid", 32'(bus.valid_out), 1);
        check("single angle", 32'(bus.angle_out), p);
        check("single sin", $signed(bus.sin_out), es);
        check("single cos", $signed(bus.cos_out), ec);
        check("single last", 32'(bus.last_out), 0);
        tick();
        check("hold valid", 32'(bus.valid_out), 0);
        check("hold sin", $signed(bus.sin_out), es);
    endtask

    task automatic start_sweep(input int a, input int s, input int n);
        bus.sweep_start_in = 1'b1;
        bus.angle_in       = 9'(a);
        bus.step_in        = 9'(s);
        bus.len_in         = 16'(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int angs[20];
        int exp_a[3];
        int seen;

        bus.valid_in = 1'b0;
        bus.angle_in = '0;
        bus.sweep_start_in = 1'b0;
        bus.step_in = '0;
        bus.len_in = '0;
        tick();
        tick();
        check("rst sin", $signed(bus.sin_out), 0);
        check("rst cos", $signed(bus.cos_out), 0);
        check("rst valid", 32'(bus.valid_out), 0);
        check("rst busy", 32'(bus.busy_out), 0);
        rst_in = 1'b0;
        tick();

        single(0, 0, 32767);
        single(128, 32767, 0);
        single(256, 0, -32767);
        single(384, -32767, 0);
        single(64, 23170, 23170);
        single(448, -23170, 23170);

        // Sweep 500/8/4 wraps through zero.
        start_sweep(500, 8, 4);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.sweep_start_in = 1'b0;
            bus.step_in = 9'd3;
            if (c <= 4) check("sw4 busy", 32'(bus.busy_out), (c <= 3) ? 1 : 0);
            if (c >= 3) begin
                int p;
                p = (500 + 8 * (c - 3)) % N;
                check_sample("sw4", p, (c == 6) ? 1 : 0);
            end
        end
        tick();
        check("sw4 end valid", 32'(bus.valid_out), 0);

        // Full circle, one phase per cycle.
        start_sweep(0, 1, 512);
        tick();
        bus.sweep_start_in = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            tick();
            check_sample("full", i, (i == N - 1) ? 1 : 0);
        end
        tick();
        check("full end valid", 32'(bus.valid_out), 0);

        // Reset two cycles into a len-10 sweep; inputs during reset are ignored.
        start_sweep(20, 3, 10);
        tick();
        bus.sweep_start_in = 1'b0;
        tick();
        rst_in = 1'b1;
        bus.valid_in = 1'b1;
        tick();
        check("abort valid", 32'(bus.valid_out), 0);
        check("abort sin", $signed(bus.sin_out), 0);
        check("abort cos", $signed(bus.cos_out), 0);
        check("abort angle", 32'(bus.angle_out), 0);
        check("abort last", 32'(bus.last_out), 0);
        check("abort busy", 32'(bus.busy_out), 0);
        rst_in = 1'b0;
        bus.valid_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen += int'(bus.valid_out) + int'(bus.busy_out);
        end
        check("abort quiet", seen, 0);

        // Zero-length start does nothing.
        start_sweep(77, 1, 0);
        tick();
        bus.sweep_start_in = 1'b0;
        check("len0 busy", 32'(bus.busy_out), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen += int'(bus.valid_out) + int'(bus.busy_out);
        end
        check("len0 quiet", seen, 0);

        // Sweep wins over a simultaneous single request.
        start_sweep(10, 5, 3);
        bus.valid_in = 1'b1;
        exp_a = '{10, 15, 20};
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.sweep_start_in = 1'b0;
            bus.valid_in = 1'b0;
            if (c >= 3 && c <= 5) check_sample("prio", exp_a[c-3], (c == 5) ? 1 : 0);
            if (c == 6) check("prio end valid", 32'(bus.valid_out), 0);
        end

        // Back-to-back random single requests.
        foreach (angs[i]) angs[i] = int'($urandom_range(511, 0));
        bus.valid_in = 1'b1;
        bus.angle_in = 9'(angs[0]);
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k < 20) bus.angle_in = 9'(angs[k]);
            else bus.valid_in = 1'b0;
            if (k >= 3) check_sample("rand", angs[k-3], 0);
        end
        tick();
        check("rand end valid", 32'(bus.valid_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
